// File: rtl/ahb_slave_mux_pkg.sv
// ahb_slave_mux_pkg: shared types, limits and parameter-slicing helper for the AHB slave mux
package ahb_slave_mux_pkg;
  localparam int MAX_NSLAVES = 16;
  localparam int MAX_ADDR_W = 64;
  localparam int PACK_W = MAX_NSLAVES * MAX_ADDR_W;
  typedef enum logic [1:0] {TR_IDLE, TR_BUSY, TR_NONSEQ, TR_SEQ} ahb_trans_e;
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} deferr_state_e;
  function automatic logic [MAX_ADDR_W-1:0] slv_field(input logic [PACK_W-1:0] v, input int i, input int w);
    logic [PACK_W-1:0] s;
    s = v >> (i * w);
    return s[MAX_ADDR_W-1:0] & ((MAX_ADDR_W'(1) << w) - MAX_ADDR_W'(1));
  endfunction
endpackage

// File: rtl/ahb_slave_mux_if.sv
// ahb_slave_mux_if: manager-side address/response bus plus per-slave fan-in/fan-out
interface ahb_slave_mux_if
  import ahb_slave_mux_pkg::*;
#(
  parameter int NSLAVES = 8,
  parameter int ADDR_W = 34,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] HADDR;
  ahb_trans_e HTRANS;
  logic [NSLAVES-1:0] HSELS;
  logic [NSLAVES-1:0] HREADYOUTS;
  logic [NSLAVES-1:0] HRESPS;
  logic [NSLAVES*DATA_W-1:0] HRDATAS;
  logic [DATA_W-1:0] HRDATA;
  logic HREADY;
  logic HRESP;
  logic TimeoutErr;
  logic [NSLAVES-1:0] StuckMask;
  modport slave (
    input HADDR, HTRANS, HREADYOUTS, HRESPS, HRDATAS,
    output HSELS, HRDATA, HREADY, HRESP, TimeoutErr, StuckMask
  );
  modport master (
    output HADDR, HTRANS, HREADYOUTS, HRESPS, HRDATAS,
    input HSELS, HRDATA, HREADY, HRESP, TimeoutErr, StuckMask
  );
endinterface

// File: rtl/ahb_slave_mux_default_slave.sv
// ahb_default_slave: two-cycle ERROR responder for unmapped transfers plus per-transfer stall watchdog
module ahb_default_slave
  import ahb_slave_mux_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_hready,
  input  logic i_unmapped,
  input  logic i_slv_sel,
  input  logic i_slv_ready,
  output logic o_active,
  output logic o_hready,
  output logic o_hresp,
  output logic o_timeout
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  deferr_state_e r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic w_wait;
  assign w_wait = (r_state == DS_IDLE) & i_slv_sel & ~i_slv_ready;
  assign o_timeout = (TIMEOUT != 0) && w_wait && (r_cnt == CW'(TIMEOUT));
  // Error sequencing: ERR1 always stalls one cycle, ERR2 completes and may chain into another error
  always_comb begin
    w_next = r_state == DS_ERR1 ? DS_ERR2 : (o_timeout | (i_hready & i_unmapped)) ? DS_ERR1 : DS_IDLE;
    o_active = r_state != DS_IDLE;
    o_hready = r_state != DS_ERR1;
    o_hresp = r_state != DS_IDLE;
  end
  // State register and wait-state counter; the counter restarts with every completed transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DS_IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= i_hready ? '0 : w_wait ? r_cnt + 1'b1 : r_cnt;
    end
  end
endmodule

// File: rtl/ahb_slave_mux.sv
// ahb_slave_mux: AHB-Lite address decoder and data-phase response mux with built-in error slave
module ahb_slave_mux
  import ahb_slave_mux_pkg::*;
#(
  parameter int NSLAVES = 8,
  parameter int ADDR_W = 34,
  parameter int DATA_W = 64,
  parameter logic [NSLAVES*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NSLAVES*ADDR_W-1:0] SLV_MASK = '0,
  parameter int TIMEOUT = 255
) (
  input logic HCLK,
  input logic reset,
  ahb_slave_mux_if.slave bus
);
  localparam logic [NSLAVES:0] DEF_SEL = {1'b1, {NSLAVES{1'b0}}};
  logic [NSLAVES-1:0] w_match, w_hsel, r_stuck;
  logic [NSLAVES:0] r_dsel;
  logic [DATA_W-1:0] w_slv_rdata;
  logic w_any, w_def, w_slv_ready, w_slv_resp;
  logic w_fsm_active, w_fsm_ready, w_fsm_resp, w_timeout;
  for (genvar i = 0; i < NSLAVES; i++) begin : g_dec
    localparam logic [MAX_ADDR_W-1:0] BASE = slv_field(PACK_W'(SLV_BASE), i, ADDR_W);
    localparam logic [MAX_ADDR_W-1:0] MASK = slv_field(PACK_W'(SLV_MASK), i, ADDR_W);
    assign w_match[i] = ((bus.HADDR & MASK[ADDR_W-1:0]) == BASE[ADDR_W-1:0]) & ~r_stuck[i];
  end
  assign w_hsel = w_match & (~w_match + NSLAVES'(1));
  assign w_any = |w_match;
  assign bus.HSELS = w_hsel;
  // Gather the response of whichever slave owns the data phase
  always_comb begin
    w_slv_rdata = '0;
    w_slv_ready = 1'b0;
    w_slv_resp = 1'b0;
    for (int i = 0; i < NSLAVES; i++) begin
      w_slv_rdata |= r_dsel[i] ? bus.HRDATAS[i*DATA_W +: DATA_W] : '0;
      w_slv_ready |= r_dsel[i] & bus.HREADYOUTS[i];
      w_slv_resp |= r_dsel[i] & bus.HRESPS[i];
    end
  end
  assign w_def = r_dsel[NSLAVES] | w_fsm_active;
  assign bus.HRDATA = w_def ? '0 : w_slv_rdata;
  assign bus.HREADY = w_def ? w_fsm_ready : w_slv_ready;
  assign bus.HRESP = w_def ? w_fsm_resp : w_slv_resp;
  assign bus.TimeoutErr = w_timeout;
  assign bus.StuckMask = r_stuck;
  // Data-phase owner advances on HREADY; a timed-out slave stays fenced until reset
  always_ff @(posedge HCLK or posedge reset) begin
    if (reset) begin
      r_dsel <= DEF_SEL;
      r_stuck <= '0;
    end else begin
      if (bus.HREADY) r_dsel <= w_any ? {1'b0, w_hsel} : DEF_SEL;
      if (w_timeout) r_stuck <= r_stuck | r_dsel[NSLAVES-1:0];
    end
  end
  ahb_default_slave #(.TIMEOUT(TIMEOUT)) u_def (
    .clk(HCLK),
    .rst(reset),
    .i_hready(bus.HREADY),
    .i_unmapped(bus.HTRANS[1] & ~w_any),
    .i_slv_sel(~r_dsel[NSLAVES]),
    .i_slv_ready(w_slv_ready),
    .o_active(w_fsm_active),
    .o_hready(w_fsm_ready),
    .o_hresp(w_fsm_resp),
    .o_timeout(w_timeout)
  );
endmodule
